// File: rtl/seq_count_sched.sv
`default_nettype none
// ============================================================================
// Module   : seq_count_sched
// Purpose  : Round-robin scheduler that shares one terminal-count sequencer
//            between NUM_REQ requesters. The winner's terminal value is
//            latched on the grant cycle. The counter then runs from 0 up to
//            that value, and a one-cycle done pulse tagged with the winner's
//            index follows.
// Ports    : clk       - rising-edge clock
//            reset     - synchronous active-high reset
//            req       - level request per requester, held for the whole run
//            term_val  - terminal count, sampled on the grant cycle only
//            abort     - ends the current run without a done pulse
//            gnt       - one-hot grant (registered)
//            q_out     - current count (registered)
//            busy      - high while running or signalling done
//            done      - one-cycle pulse after the terminal count
//            done_id   - index of the requester that completed, held
//            done_cnt  - saturating count of completed runs
// Revision : 1.0 - initial release
// ============================================================================
module seq_count_sched #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 2,
    parameter int DCNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [CNT_W-1:0]           term_val,
    input  logic                       abort,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [CNT_W-1:0]           q_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic [DCNT_W-1:0]          done_cnt
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0]    c_st_idle = 2'd0;
    localparam logic [1:0]    c_st_run  = 2'd1;
    localparam logic [1:0]    c_st_done = 2'd2;
    localparam logic [ID_W:0] c_num_req = (ID_W+1)'(NUM_REQ);

    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]   r_term_lat;
    logic [ID_W-1:0]    r_id_lat;
    logic [NUM_REQ-1:0] r_gnt;
    logic [CNT_W-1:0]   r_q;
    logic               r_busy;
    logic               r_done;
    logic [ID_W-1:0]    r_done_id;
    logic [DCNT_W-1:0]  r_done_cnt;

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic                 w_found;
    logic [ID_W-1:0]      w_ofs;
    logic [ID_W:0]        w_sum;
    logic [ID_W-1:0]      w_winner;
    logic [ID_W:0]        w_nxt_sum;
    logic [ID_W-1:0]      w_nxt_ptr;
    logic                 w_gnt_held;

    // Rotate the request vector so that bit 0 corresponds to rr_ptr. The
    // lowest set bit of the rotated vector is then the round-robin winner,
    // expressed as an offset from rr_ptr.
    assign w_req_dbl = {req, req};
    assign w_req_rot = NUM_REQ'(w_req_dbl >> r_rr_ptr);

    always_comb begin
        w_found = 1'b0;
        w_ofs   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_found = 1'b1;
                w_ofs   = ID_W'(i);
            end
        end
    end

    // Map the offset back to an absolute index. NUM_REQ need not be a power
    // of two, so the wrap is a single conditional subtract, not a truncation.
    assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_ofs};
    assign w_winner  = (w_sum >= c_num_req) ? ID_W'(w_sum - c_num_req)
                                            : w_sum[ID_W-1:0];
    assign w_nxt_sum = {1'b0, w_winner} + {{ID_W{1'b0}}, 1'b1};
    assign w_nxt_ptr = (w_nxt_sum == c_num_req) ? '0 : w_nxt_sum[ID_W-1:0];

    // The granted requester still holds its request.
    assign w_gnt_held = |(req & r_gnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_rr_ptr   <= '0;
            r_term_lat <= '0;
            r_id_lat   <= '0;
            r_gnt      <= '0;
            r_q        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_done_id  <= '0;
            r_done_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_state    <= c_st_run;
                        r_gnt      <= NUM_REQ'(1) << w_winner;
                        r_q        <= '0;
                        r_term_lat <= term_val;
                        r_id_lat   <= w_winner;
                        r_rr_ptr   <= w_nxt_ptr;
                        r_busy     <= 1'b1;
                    end
                end
                c_st_run: begin
                    // An abort outranks a terminal match in the same cycle.
                    // The round-robin pointer has already moved past the
                    // aborted winner and stays there.
                    if (abort || !w_gnt_held) begin
                        r_state <= c_st_idle;
                        r_gnt   <= '0;
                        r_q     <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_q == r_term_lat) begin
                        r_state   <= c_st_done;
                        r_gnt     <= '0;
                        r_done    <= 1'b1;
                        r_done_id <= r_id_lat;
                        if (r_done_cnt != {DCNT_W{1'b1}}) begin
                            r_done_cnt <= r_done_cnt + 1'b1;
                        end
                    end else begin
                        r_q <= r_q + 1'b1;
                    end
                end
                c_st_done: begin
                    // q_out holds the terminal value for this one cycle and
                    // then returns to zero in IDLE.
                    r_state <= c_st_idle;
                    r_q     <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_gnt   <= '0;
                    r_q     <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign q_out    = r_q;
    assign busy     = r_busy;
    assign done     = r_done;
    assign done_id  = r_done_id;
    assign done_cnt = r_done_cnt;

endmodule
`default_nettype wire
